// File: rtl/cross_bar_slave_arb.sv
// Slave-side arbiter of the crossbar: picks one master whose address
// decodes to this slave (round-robin), forwards its latched request and
// routes ack / read response back to it until the transaction completes.
//
// Handshake: a master holds m_req until its m_ack bit pulses; the slave
// accepts with s_ack while s_req is high; a read then completes on the
// first s_resp strobe seen after the accept. All strobes are one cycle.
module cross_bar_slave_arb #(
  parameter int MASTER_N = 4,
  parameter int MASTER_W = $clog2(MASTER_N),
  parameter int SLAVE_N  = 4,
  parameter int SLAVE_W  = $clog2(SLAVE_N),
  parameter int SLAVE_ID = 0,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MASTER_N-1:0]        m_req,
  input  logic [MASTER_N-1:0]        m_cmd,
  input  logic [MASTER_N*ADDR_W-1:0] m_addr,
  input  logic [MASTER_N*DATA_W-1:0] m_wdata,
  output logic [MASTER_N-1:0]        m_ack,
  output logic [MASTER_N-1:0]        m_resp,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       s_req,
  output logic                       s_cmd,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic                       s_ack,
  input  logic                       s_resp,
  input  logic [DATA_W-1:0]          s_rdata,
  output logic                       grant_valid,
  output logic [MASTER_W-1:0]        grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [SLAVE_W-1:0]  SLAVE_SEL  = SLAVE_W'(SLAVE_ID);
  localparam logic [MASTER_W:0]   MASTER_N_W = (MASTER_W + 1)'(MASTER_N);
  localparam logic [MASTER_W-1:0] LAST_ID    = MASTER_W'(MASTER_N - 1);

  state_e              state_q, state_d;
  logic [MASTER_W-1:0] ptr_q, ptr_d;
  logic [MASTER_W-1:0] grant_id_q, grant_id_d;
  logic                grant_valid_q, grant_valid_d;
  logic                s_cmd_q, s_cmd_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;

  logic [MASTER_N-1:0] hit;
  logic                pick_found;
  logic [MASTER_W-1:0] pick_id;
  logic [MASTER_W:0]   idx_wide;
  logic [MASTER_W-1:0] idx;
  logic [MASTER_W-1:0] ptr_inc;
  logic [MASTER_N-1:0] grant_oh;

  // Address decode: a master competes only if its top address bits select this slave.
  always_comb begin
    hit = '0;
    for (int i = 0; i < MASTER_N; i++) begin
      hit[i] = m_req[i] && (m_addr[i*ADDR_W + ADDR_W - 1 -: SLAVE_W] == SLAVE_SEL);
    end
  end

  // Round-robin search: first hit at or after ptr, wrapping past the last master.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx_wide   = '0;
    idx        = '0;
    for (int k = 0; k < MASTER_N; k++) begin
      idx_wide = {1'b0, ptr_q} + (MASTER_W + 1)'(k);
      if (idx_wide >= MASTER_N_W) idx_wide = idx_wide - MASTER_N_W;
      idx = idx_wide[MASTER_W-1:0];
      if (!pick_found && hit[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  // Pointer successor of the current owner and its one-hot return vector.
  always_comb begin
    ptr_inc  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + MASTER_W'(1);
    grant_oh = '0;
    grant_oh[grant_id_q] = 1'b1;
  end

  // Next-state logic: grant in IDLE, forward in REQ, wait for read data in RESP.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    s_cmd_d       = s_cmd_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = REQ;
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          s_cmd_d       = m_cmd[pick_id];
          s_addr_d      = m_addr[pick_id*ADDR_W +: ADDR_W];
          s_wdata_d     = m_wdata[pick_id*DATA_W +: DATA_W];
        end
      end
      REQ: begin
        if (s_ack) begin
          if (s_cmd_q) begin
            state_d       = IDLE;
            ptr_d         = ptr_inc;
            grant_valid_d = 1'b0;
            s_cmd_d       = 1'b0;
            s_addr_d      = '0;
            s_wdata_d     = '0;
          end else begin
            // A same-cycle s_resp is ignored here; the response comes later.
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (s_resp) begin
          state_d       = IDLE;
          ptr_d         = ptr_inc;
          grant_valid_d = 1'b0;
          s_cmd_d       = 1'b0;
          s_addr_d      = '0;
          s_wdata_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      s_cmd_q       <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      s_cmd_q       <= s_cmd_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
    end
  end

  // Return path: ack only in REQ, response and data only in RESP, to the owner only.
  always_comb begin
    m_ack   = (state_q == REQ  && s_ack)  ? grant_oh : '0;
    m_resp  = (state_q == RESP && s_resp) ? grant_oh : '0;
    m_rdata = (state_q == RESP && s_resp) ? s_rdata  : '0;
  end

  assign s_req       = (state_q == REQ);
  assign s_cmd       = s_cmd_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_cross_bar_slave_arb.sv
// Directed bench for cross_bar_slave_arb. Inputs change on the falling
// edge; outputs are checked 1 ns later, away from the rising edge.
// A second instance with SLAVE_ID=1 shares the master buses for the
// address-decode test.
module tb_cross_bar_slave_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req;
  logic [3:0]   m_cmd;
  logic [127:0] m_addr;
  logic [127:0] m_wdata;
  logic         s_ack0, s_resp0, s_ack1, s_resp1;
  logic [31:0]  s_rdata0, s_rdata1;

  logic [3:0]  m_ack0, m_resp0, m_ack1, m_resp1;
  logic [31:0] m_rdata0, m_rdata1;
  logic        s_req0, s_cmd0, s_req1, s_cmd1;
  logic [31:0] s_addr0, s_wdata0, s_addr1, s_wdata1;
  logic        gv0, gv1;
  logic [1:0]  gid0, gid1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cross_bar_slave_arb #(.SLAVE_ID(0)) dut0 (
    .clk(clk), .rst(rst), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack0), .m_resp(m_resp0), .m_rdata(m_rdata0),
    .s_req(s_req0), .s_cmd(s_cmd0), .s_addr(s_addr0), .s_wdata(s_wdata0),
    .s_ack(s_ack0), .s_resp(s_resp0), .s_rdata(s_rdata0),
    .grant_valid(gv0), .grant_id(gid0)
  );

  cross_bar_slave_arb #(.SLAVE_ID(1)) dut1 (
    .clk(clk), .rst(rst), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack1), .m_resp(m_resp1), .m_rdata(m_rdata1),
    .s_req(s_req1), .s_cmd(s_cmd1), .s_addr(s_addr1), .s_wdata(s_wdata1),
    .s_ack(s_ack1), .s_resp(s_resp1), .s_rdata(s_rdata1),
    .grant_valid(gv1), .grant_id(gid1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int i, input logic req, input logic cmd,
                       input logic [31:0] addr, input logic [31:0] wdata);
    m_req[i]             = req;
    m_cmd[i]             = cmd;
    m_addr[i*32 +: 32]   = addr;
    m_wdata[i*32 +: 32]  = wdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack0 = 0; s_resp0 = 0; s_rdata0 = '0;
    s_ack1 = 0; s_resp1 = 0; s_rdata1 = '0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    check_eq("rst_s_req",  32'(s_req0), 32'd0);
    check_eq("rst_s_cmd",  32'(s_cmd0), 32'd0);
    check_eq("rst_s_addr", s_addr0, 32'd0);
    check_eq("rst_s_wdata", s_wdata0, 32'd0);
    check_eq("rst_m_ack",  32'(m_ack0), 32'd0);
    check_eq("rst_m_resp", 32'(m_resp0), 32'd0);
    check_eq("rst_m_rdata", m_rdata0, 32'd0);
    check_eq("rst_gv",     32'(gv0), 32'd0);
    check_eq("rst_gid",    32'(gid0), 32'd0);

    // ---------------- single write from master 2 ----------------
    next_cyc();
    set_m(2, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    settle();
    check_eq("wr_sreq_pre", 32'(s_req0), 32'd0);
    next_cyc();
    s_ack0 = 1'b1;
    settle();
    check_eq("wr_sreq",  32'(s_req0), 32'd1);
    check_eq("wr_scmd",  32'(s_cmd0), 32'd1);
    check_eq("wr_saddr", s_addr0, 32'h0000_0010);
    check_eq("wr_swdata", s_wdata0, 32'hDEAD_BEEF);
    check_eq("wr_mack",  32'(m_ack0), 32'b0100);
    check_eq("wr_gid",   32'(gid0), 32'd2);
    check_eq("wr_gv",    32'(gv0), 32'd1);
    next_cyc();
    s_ack0 = 1'b0;
    set_m(2, 1'b0, 1'b0, 32'h0, 32'h0);
    // ptr is now 3: masters 0 and 3 together must give 3 first, then 0
    set_m(0, 1'b1, 1'b1, 32'h0000_0000, 32'h1111_0000);
    set_m(3, 1'b1, 1'b1, 32'h0000_0030, 32'h3333_0000);
    settle();
    check_eq("wr_mack_done", 32'(m_ack0), 32'd0);
    check_eq("wr_sreq_done", 32'(s_req0), 32'd0);
    check_eq("wr_gv_done",   32'(gv0), 32'd0);
    check_eq("wr_saddr_clr", s_addr0, 32'd0);
    next_cyc();
    s_ack0 = 1'b1;
    settle();
    check_eq("ptr3_gid",  32'(gid0), 32'd3);
    check_eq("ptr3_mack", 32'(m_ack0), 32'b1000);
    check_eq("ptr3_wdata", s_wdata0, 32'h3333_0000);
    next_cyc();
    s_ack0 = 1'b0;
    set_m(3, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check_eq("ptr3_gap", 32'(s_req0), 32'd0);
    next_cyc();
    s_ack0 = 1'b1;
    settle();
    check_eq("ptr0_gid",  32'(gid0), 32'd0);
    check_eq("ptr0_mack", 32'(m_ack0), 32'b0001);
    next_cyc();
    s_ack0 = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- read from master 1 ----------------
    do_reset();
    next_cyc();
    set_m(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    next_cyc();
    s_ack0  = 1'b1;
    s_resp0 = 1'b1;  // same-cycle response must be ignored
    s_rdata0 = 32'hCAFE_0000;
    settle();
    check_eq("rd_mack",  32'(m_ack0), 32'b0010);
    check_eq("rd_mresp_inreq", 32'(m_resp0), 32'd0);
    check_eq("rd_scmd",  32'(s_cmd0), 32'd0);
    check_eq("rd_gv_req", 32'(gv0), 32'd1);
    next_cyc();
    s_ack0 = 1'b0;
    s_resp0 = 1'b0;
    s_rdata0 = 32'hFFFF_FFFF;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check_eq("rd_sreq_resp", 32'(s_req0), 32'd0);
    check_eq("rd_rdata_gated", m_rdata0, 32'd0);
    check_eq("rd_gv_wait1", 32'(gv0), 32'd1);
    s_ack0 = 1'b1;  // ack while in RESP is ignored
    next_cyc();
    settle();
    check_eq("rd_mack_inresp", 32'(m_ack0), 32'd0);
    check_eq("rd_gv_wait2", 32'(gv0), 32'd1);
    s_ack0 = 1'b0;
    next_cyc();
    settle();
    check_eq("rd_mresp_wait", 32'(m_resp0), 32'd0);
    next_cyc();
    s_resp0 = 1'b1;
    s_rdata0 = 32'h1234_5678;
    settle();
    check_eq("rd_mresp",  32'(m_resp0), 32'b0010);
    check_eq("rd_mrdata", m_rdata0, 32'h1234_5678);
    check_eq("rd_gv_resp", 32'(gv0), 32'd1);
    next_cyc();
    s_resp0 = 1'b0;
    settle();
    check_eq("rd_mresp_done", 32'(m_resp0), 32'd0);
    check_eq("rd_gv_done", 32'(gv0), 32'd0);
    s_resp0 = 1'b1;  // stray response in IDLE
    settle();
    check_eq("rd_mresp_idle", 32'(m_resp0), 32'd0);
    check_eq("rd_mrdata_idle", m_rdata0, 32'd0);
    s_resp0 = 1'b0;

    // ---------------- decode filter on SLAVE_ID=1 ----------------
    do_reset();
    next_cyc();
    set_m(0, 1'b1, 1'b1, 32'h4000_0000, 32'h0000_00AA);
    set_m(3, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_00BB);
    next_cyc();
    s_ack1 = 1'b1;
    settle();
    check_eq("dec_gid",  32'(gid1), 32'd0);
    check_eq("dec_mack", 32'(m_ack1), 32'b0001);
    check_eq("dec_saddr", s_addr1, 32'h4000_0000);
    next_cyc();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("dec_m3_ack", 32'(m_ack1), 32'd0);
      check_eq("dec_m3_gv",  32'(gv1), 32'd0);
      next_cyc();
    end
    s_ack1 = 1'b0;
    m_req = '0;

    // ---------------- round robin, immediate ack ----------------
    do_reset();
    next_cyc();
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b1, 32'h0000_0100 + 32'(i), 32'h0);
    s_ack0 = 1'b1;
    begin
      logic [1:0] order [5];
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
      for (int g = 0; g < 5; g++) begin
        next_cyc();
        settle();
        check_eq("rr_gid",  32'(gid0), 32'(order[g]));
        check_eq("rr_mack", 32'(m_ack0), 32'(4'b0001 << order[g]));
        next_cyc();
        settle();
        check_eq("rr_idle_gap", 32'(s_req0), 32'd0);
      end
    end
    s_ack0 = 1'b0;
    m_req = '0;

    // ---------------- stall with changing master inputs ----------------
    do_reset();
    next_cyc();
    set_m(0, 1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_0000);
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      m_wdata[31:0] = 32'(i);
      m_addr[31:0]  = 32'h0000_0200 + 32'(i * 4);
      if (i == 5) m_req[0] = 1'b0;
      settle();
      check_eq("st_sreq",  32'(s_req0), 32'd1);
      check_eq("st_saddr", s_addr0, 32'h0000_0100);
      check_eq("st_swdata", s_wdata0, 32'hA5A5_0000);
      check_eq("st_mack",  32'(m_ack0), 32'd0);
    end
    next_cyc();
    s_ack0 = 1'b1;
    settle();
    check_eq("st_mack_end", 32'(m_ack0), 32'b0001);
    next_cyc();
    s_ack0 = 1'b0;
    settle();
    check_eq("st_sreq_done", 32'(s_req0), 32'd0);
    check_eq("st_swdata_clr", s_wdata0, 32'd0);

    // ---------------- reset during RESP ----------------
    do_reset();
    next_cyc();
    set_m(2, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    next_cyc();
    s_ack0 = 1'b1;
    settle();
    check_eq("rr_rd_mack", 32'(m_ack0), 32'b0100);
    next_cyc();
    s_ack0 = 1'b0;
    set_m(2, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check_eq("rsp_gv_before", 32'(gv0), 32'd1);
    next_cyc();
    rst = 1'b1;
    s_resp0 = 1'b1;
    s_rdata0 = 32'h5555_AAAA;
    settle();
    check_eq("rsp_rst_gv",    32'(gv0), 32'd0);
    check_eq("rsp_rst_gid",   32'(gid0), 32'd0);
    check_eq("rsp_rst_mresp", 32'(m_resp0), 32'd0);
    check_eq("rsp_rst_rdata", m_rdata0, 32'd0);
    check_eq("rsp_rst_saddr", s_addr0, 32'd0);
    next_cyc();
    rst = 1'b0;
    settle();
    check_eq("rsp_late_mresp", 32'(m_resp0), 32'd0);
    s_resp0 = 1'b0;
    for (int i = 0; i < 4; i++) set_m(i, 1'b1, 1'b1, 32'h0000_0000, 32'h0);
    next_cyc();
    settle();
    check_eq("rsp_next_gid", 32'(gid0), 32'd0);
    check_eq("rsp_next_sreq", 32'(s_req0), 32'd1);
    m_req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
